// File: rtl/lane_adder_pipe.sv
// Multi-lane adder with an elastic valid/ready pipeline and per-lane accumulate mode.
// Optional saturation of results and accumulators is enabled by defining LANE_ADDER_SAT_EN.
module lane_adder_pipe #(
    parameter int WIDTH  = 8,
    parameter int LANES  = 4,
    parameter int STAGES = 2,
    parameter int BIAS   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_x,
    input  logic [LANES*WIDTH-1:0] in_y,
    input  logic                   mode,
    input  logic                   acc_clr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_sum,
    output logic [LANES-1:0]       out_carry
);

    localparam int N = LANES * WIDTH;
    localparam logic [WIDTH-1:0] BIAS_W = WIDTH'(BIAS);

    // Handshake: a beat moves across an interface on a clock edge where valid && ready.
    // The whole pipeline advances together whenever the output slot is empty or being drained.
    logic advance;
    logic accept;

    logic [WIDTH-1:0] acc      [LANES];
    logic [WIDTH-1:0] acc_next [LANES];

    logic [N-1:0]     beat_sum;
    logic [LANES-1:0] beat_carry;

    logic [STAGES-1:0] stage_valid;
    logic [N-1:0]      stage_sum   [STAGES];
    logic [LANES-1:0]  stage_carry [STAGES];

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;

    // The result is formed at accept time so the accumulator and the beat agree.
    always_comb begin : lane_math
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] base;
        logic [WIDTH-1:0] lane_sum;
        logic [WIDTH+1:0] add_full;
        logic [WIDTH:0]   acc_full;
        logic             lane_carry;
        x          = '0;
        y          = '0;
        base       = '0;
        lane_sum   = '0;
        add_full   = '0;
        acc_full   = '0;
        lane_carry = 1'b0;
        beat_sum   = '0;
        beat_carry = '0;
        for (int i = 0; i < LANES; i++) begin
            x        = in_x[i*WIDTH +: WIDTH];
            y        = in_y[i*WIDTH +: WIDTH];
            base     = acc_clr ? '0 : acc[i];
            add_full = {2'b00, x} + {2'b00, y} + {2'b00, BIAS_W};
            acc_full = {1'b0, base} + {1'b0, x};
            if (mode) begin
                lane_sum   = acc_full[WIDTH-1:0];
                lane_carry = acc_full[WIDTH];
            end else begin
                lane_sum   = add_full[WIDTH-1:0];
                lane_carry = |add_full[WIDTH+1:WIDTH];
            end
`ifdef LANE_ADDER_SAT_EN
            if (lane_carry) begin
                lane_sum = '1;
            end
`endif
            beat_sum[i*WIDTH +: WIDTH] = lane_sum;
            beat_carry[i]              = lane_carry;
            acc_next[i]                = acc[i];
            if (acc_clr) begin
                acc_next[i] = '0;
            end
            if (accept && mode) begin
                acc_next[i] = lane_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= '0;
            for (int s = 0; s < STAGES; s++) begin
                stage_sum[s]   <= '0;
                stage_carry[s] <= '0;
            end
            for (int i = 0; i < LANES; i++) begin
                acc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                acc[i] <= acc_next[i];
            end
            if (advance) begin
                stage_valid[0] <= accept;
                stage_sum[0]   <= beat_sum;
                stage_carry[0] <= beat_carry;
                for (int s = 1; s < STAGES; s++) begin
                    stage_valid[s] <= stage_valid[s-1];
                    stage_sum[s]   <= stage_sum[s-1];
                    stage_carry[s] <= stage_carry[s-1];
                end
            end
        end
    end

    assign out_valid = stage_valid[STAGES-1];
    assign out_sum   = stage_sum[STAGES-1];
    assign out_carry = stage_carry[STAGES-1];

endmodule

// File: tb/tb_lane_adder_pipe.sv
// Bench for lane_adder_pipe: directed scenarios plus randomized traffic against a lane-level model.
// Expectations follow the LANE_ADDER_SAT_EN setting of the build.
module tb_lane_adder_pipe;

    localparam int W = 8;
    localparam int L = 4;
    localparam int S = 2;
    localparam int B = 0;
    localparam int N = L * W;
    localparam longint M = 64'd1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_x;
    logic [N-1:0] in_y;
    logic         mode;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_sum;
    logic [L-1:0] out_carry;

    int errors = 0;
    int checks = 0;
    logic [N+L-1:0] exp_q[$];
    longint model_acc[L];

    lane_adder_pipe #(.WIDTH(W), .LANES(L), .STAGES(S), .BIAS(B)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .mode(mode), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry)
    );

    always #5 clk = ~clk;

    // Lane-level model: plain integer arithmetic on each lane.
    function automatic logic [N+L-1:0] model_beat(input logic [N-1:0] x, input logic [N-1:0] y,
                                                  input logic m, input logic c);
        logic [N-1:0] s;
        logic [L-1:0] cy;
        longint full;
        longint sv;
        s  = '0;
        cy = '0;
        if (c) for (int i = 0; i < L; i++) model_acc[i] = 0;
        for (int i = 0; i < L; i++) begin
            if (m) full = model_acc[i] + longint'(x[i*W +: W]);
            else   full = longint'(x[i*W +: W]) + longint'(y[i*W +: W]) + B;
            cy[i] = (full >= M);
            sv = full % M;
`ifdef LANE_ADDER_SAT_EN
            if (cy[i]) sv = M - 1;
`endif
            if (m) model_acc[i] = sv;
            s[i*W +: W] = sv[W-1:0];
        end
        return {cy, s};
    endfunction

    // Scoreboard: samples on the falling edge what the next rising edge will transfer.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < L; i++) model_acc[i] = 0;
        end else begin
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL in_ready: got %b want %b", in_ready, !out_valid || out_ready);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got sum=%h carry=%b with nothing expected", out_sum, out_carry);
                end else begin
                    logic [N+L-1:0] e;
                    e = exp_q.pop_front();
                    if ({out_carry, out_sum} !== e) begin
                        errors++;
                        $display("FAIL beat: got carry=%b sum=%h want carry=%b sum=%h",
                                 out_carry, out_sum, e[N+L-1:N], e[N-1:0]);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model_beat(in_x, in_y, mode, acc_clr));
            end else if (acc_clr) begin
                for (int i = 0; i < L; i++) model_acc[i] = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        in_valid = 1'b0;
        mode     = 1'b0;
        acc_clr  = 1'b0;
        in_x     = '0;
        in_y     = '0;
    endtask

    task automatic drain;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d beats outstanding want 0", exp_q.size());
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        out_ready = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (out_sum !== '0) begin errors++; $display("FAIL reset_out_sum: got %h want 0", out_sum); end
        if (out_carry !== '0) begin errors++; $display("FAIL reset_out_carry: got %b want 0", out_carry); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_add;
        out_ready = 1'b1;
        mode      = 1'b0;
        in_x      = 32'h0000_FF7F;
        in_y      = 32'h0000_0101;
        in_valid  = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL add_early: got out_valid=%b want 0", out_valid); end
        tick();
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency: got out_valid=%b want 1", out_valid); end
        if (out_sum !== 32'h0000_0080) begin errors++; $display("FAIL add_sum: got %h want 00000080", out_sum); end
        if (out_carry !== 4'b0010) begin errors++; $display("FAIL add_carry: got %b want 0010", out_carry); end
        tick();
    endtask

    task automatic test_acc;
        logic [W-1:0] got_s[3];
        logic         got_c[3];
        logic [W-1:0] want_s[3];
        logic         want_c[3];
        int n = 0;
        want_s[0] = 8'h80; want_c[0] = 1'b0;
`ifdef LANE_ADDER_SAT_EN
        want_s[1] = 8'hFF; want_c[1] = 1'b1;
`else
        want_s[1] = 8'h00; want_c[1] = 1'b1;
`endif
        want_s[2] = 8'h80; want_c[2] = 1'b0;
        out_ready = 1'b1;
        mode      = 1'b1;
        in_x      = 32'h0080_0000;
        in_y      = $urandom;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 3);
            acc_clr  = (c == 2);
            tick();
            if (out_valid && n < 3) begin
                got_s[n] = out_sum[2*W +: W];
                got_c[n] = out_carry[2];
                n++;
            end
        end
        idle_inputs();
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL acc_count: got %0d beats want 3", n);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (got_s[k] !== want_s[k] || got_c[k] !== want_c[k]) begin
                    errors++;
                    $display("FAIL acc_beat%0d: got %h c%b want %h c%b", k, got_s[k], got_c[k], want_s[k], want_c[k]);
                end
            end
        end
        mode     = 1'b1;
        in_valid = 1'b1;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (out_sum[2*W +: W] !== 8'h80 || out_carry[2] !== 1'b0) begin
            errors++;
            $display("FAIL acc_after_clr: got %h c%b want 80 c0", out_sum[2*W +: W], out_carry[2]);
        end
        tick();
    endtask

    task automatic test_sat;
        logic [W-1:0] ovf_sum;
        logic [W-1:0] acc_ovf;
`ifdef LANE_ADDER_SAT_EN
        ovf_sum = 8'hFF;
        acc_ovf = 8'hFF;
`else
        ovf_sum = 8'h00;
        acc_ovf = 8'h10;
`endif
        out_ready = 1'b1;
        mode      = 1'b0;
        in_x      = 32'h0000_FF00;
        in_y      = 32'h0000_0100;
        in_valid  = 1'b1;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (out_sum[W +: W] !== ovf_sum || out_carry[1] !== 1'b1) begin
            errors++;
            $display("FAIL sat_add: got %h c%b want %h c1", out_sum[W +: W], out_carry[1], ovf_sum);
        end
        acc_clr = 1'b1;
        tick();
        acc_clr  = 1'b0;
        mode     = 1'b1;
        in_valid = 1'b1;
        in_x     = 32'h0000_F000;
        tick();
        in_x = 32'h0000_2000;
        tick();
        checks++;
        if (out_sum[W +: W] !== 8'hF0 || out_carry[1] !== 1'b0) begin
            errors++;
            $display("FAIL sat_acc_first: got %h c%b want f0 c0", out_sum[W +: W], out_carry[1]);
        end
        in_x = '0;
        tick();
        checks++;
        if (out_sum[W +: W] !== acc_ovf || out_carry[1] !== 1'b1) begin
            errors++;
            $display("FAIL sat_acc_ovf: got %h c%b want %h c1", out_sum[W +: W], out_carry[1], acc_ovf);
        end
        idle_inputs();
        tick();
        checks++;
        if (out_sum[W +: W] !== acc_ovf || out_carry[1] !== 1'b0) begin
            errors++;
            $display("FAIL sat_acc_hold: got %h c%b want %h c0", out_sum[W +: W], out_carry[1], acc_ovf);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [N-1:0] held = '0;
        logic stalled = 1'b0;
        int sent = 0;
        int drops = 0;
        for (int c = 0; c < 20; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (sent < 5);
            mode      = 1'b0;
            in_x      = $urandom;
            in_y      = $urandom;
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (out_sum !== held) begin
                    errors++;
                    $display("FAIL stall_stable: got %h want %h", out_sum, held);
                end
            end
            stalled = out_valid && !out_ready;
            held    = out_sum;
            if (!in_ready) drops++;
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        idle_inputs();
        out_ready = 1'b1;
        checks += 2;
        if (sent != 5) begin errors++; $display("FAIL b2b_sent: got %0d want 5", sent); end
        if (drops == 0) begin errors++; $display("FAIL b2b_backpressure: got in_ready never low want low while stalled"); end
        drain();
    endtask

    task automatic test_reset_midstream;
        logic [N-1:0] x;
        out_ready = 1'b1;
        mode      = 1'b1;
        in_x      = {L{8'h11}};
        in_valid  = 1'b1;
        tick();
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
        if (out_sum !== '0) begin errors++; $display("FAIL rst_mid_sum: got %h want 0", out_sum); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_flush: got %b want 0", out_valid); end
        x        = $urandom;
        in_x     = x;
        mode     = 1'b1;
        in_valid = 1'b1;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (out_sum !== x || out_carry !== '0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_fresh: got v%b %h c%b want v1 %h c0", out_valid, out_sum, out_carry, x);
        end
        tick();
    endtask

    task automatic test_random;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_x      = $urandom;
            in_y      = $urandom;
            mode      = 1'($urandom_range(0, 1));
            acc_clr   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        idle_inputs();
        out_ready = 1'b1;
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        idle_inputs();
        test_reset();
        test_add();
        test_acc();
        test_sat();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
